// File: rtl/rvc_mem_arb_5pl_if.sv
// Bus bundle for the 5-stage core's shared memory port arbiter.
// Groups three channels:
//   Core : memory-stage request (CoreReqQ103H/CoreWrEn/CoreAddr/CoreWrData/CoreByteEn),
//          stall and read-return flag (CoreStall/CoreRdValidQ104H)
//   Host : valid/ready request channel, read return, and core-hold handshake
//   Mem  : single synchronous memory port (read data one cycle after MemRdEn)
// Modports: slave = the arbiter's view, master = the requesters/memory view.
interface rvc_mem_arb_5pl_if;
    // Core channel
    logic        CoreReqQ103H;
    logic        CoreWrEn;
    logic [31:0] CoreAddr;
    logic [31:0] CoreWrData;
    logic [3:0]  CoreByteEn;
    logic        CoreStall;
    logic        CoreRdValidQ104H;
    // Host channel
    logic        HostReqValid;
    logic        HostReqReady;
    logic        HostWrEn;
    logic [31:0] HostAddr;
    logic [31:0] HostWrData;
    logic [3:0]  HostByteEn;
    logic        HostRdValid;
    logic [31:0] HostRdData;
    logic        HostHoldCore;
    logic        CoreHoldAck;
    // Memory port
    logic [31:0] MemAddr;
    logic [31:0] MemWrData;
    logic [3:0]  MemByteEn;
    logic        MemWrEn;
    logic        MemRdEn;
    logic [31:0] MemRdData;

    modport slave (
        input  CoreReqQ103H, CoreWrEn, CoreAddr, CoreWrData, CoreByteEn,
        output CoreStall, CoreRdValidQ104H,
        input  HostReqValid, HostWrEn, HostAddr, HostWrData, HostByteEn, HostHoldCore,
        output HostReqReady, HostRdValid, HostRdData, CoreHoldAck,
        output MemAddr, MemWrData, MemByteEn, MemWrEn, MemRdEn,
        input  MemRdData
    );

    modport master (
        output CoreReqQ103H, CoreWrEn, CoreAddr, CoreWrData, CoreByteEn,
        input  CoreStall, CoreRdValidQ104H,
        output HostReqValid, HostWrEn, HostAddr, HostWrData, HostByteEn, HostHoldCore,
        input  HostReqReady, HostRdValid, HostRdData, CoreHoldAck,
        input  MemAddr, MemWrData, MemByteEn, MemWrEn, MemRdEn,
        output MemRdData
    );
endinterface

// File: rtl/rvc_mem_arb_5pl.sv
// Arbiter/sequencer for the single shared memory port of the 5-stage core.
// Shares the port between the core memory stage and a host (loader/debug)
// port, with starvation-bounded fairness, a core-hold mode for program
// loading, and routing of the 1-cycle read data back to its owner.
// Ports:
//   Clock : core clock
//   Rst   : synchronous, active-low reset
//   bus   : rvc_mem_arb_5pl_if.slave (core, host and memory channels)
module rvc_mem_arb_5pl #(
    parameter int unsigned MAX_CORE_WIN = 4,
    parameter int unsigned CNT_W        = 3
) (
    input  logic                 Clock,
    input  logic                 Rst,
    rvc_mem_arb_5pl_if.slave     bus
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        HOLD_ENTER = 2'd1,
        HOLD       = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CORE_WIN);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             rd_own_core_q, rd_own_core_d;
    logic             rd_own_host_q, rd_own_host_d;

    logic core_gnt, host_gnt, host_rdy, stall, hold_ack;

    always_ff @(posedge Clock) begin
        if (!Rst) begin
            state_q       <= RUN;
            starve_cnt_q  <= '0;
            rd_own_core_q <= 1'b0;
            rd_own_host_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            starve_cnt_q  <= starve_cnt_d;
            rd_own_core_q <= rd_own_core_d;
            rd_own_host_q <= rd_own_host_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        core_gnt = 1'b0;
        host_gnt = 1'b0;
        host_rdy = 1'b0;
        stall    = 1'b0;
        hold_ack = 1'b0;
        unique case (state_q)
            RUN: begin
                // Host wins when alone, or when the core has used up its window.
                if (bus.HostReqValid && (!bus.CoreReqQ103H || starve_cnt_q == MAX_CNT)) begin
                    host_gnt = 1'b1;
                    host_rdy = 1'b1;
                    stall    = bus.CoreReqQ103H;
                end else if (bus.CoreReqQ103H) begin
                    core_gnt = 1'b1;
                end
                // The op granted in this cycle still completes before entering hold.
                if (bus.HostHoldCore) state_d = HOLD_ENTER;
            end
            HOLD_ENTER: begin
                stall   = 1'b1;
                state_d = bus.HostHoldCore ? HOLD : RUN;
            end
            HOLD: begin
                stall    = 1'b1;
                hold_ack = 1'b1;
                host_rdy = 1'b1;
                host_gnt = bus.HostReqValid;
                if (!bus.HostHoldCore) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
        // No memory traffic is issued while reset is asserted.
        if (!Rst) begin
            core_gnt = 1'b0;
            host_gnt = 1'b0;
            host_rdy = 1'b0;
        end
    end

    always_comb begin
        if (!bus.HostReqValid || host_gnt) starve_cnt_d = '0;
        else if (core_gnt)                 starve_cnt_d = starve_cnt_q + 1'b1;
        else                               starve_cnt_d = starve_cnt_q;
    end

    always_comb begin
        bus.MemAddr   = '0;
        bus.MemWrData = '0;
        bus.MemByteEn = '0;
        bus.MemWrEn   = 1'b0;
        bus.MemRdEn   = 1'b0;
        if (core_gnt) begin
            bus.MemAddr   = bus.CoreAddr;
            bus.MemWrData = bus.CoreWrData;
            bus.MemByteEn = bus.CoreByteEn;
            bus.MemWrEn   = bus.CoreWrEn;
            bus.MemRdEn   = !bus.CoreWrEn;
        end else if (host_gnt) begin
            bus.MemAddr   = bus.HostAddr;
            bus.MemWrData = bus.HostWrData;
            bus.MemByteEn = bus.HostByteEn;
            bus.MemWrEn   = bus.HostWrEn;
            bus.MemRdEn   = !bus.HostWrEn;
        end
    end

    assign rd_own_core_d = core_gnt && !bus.CoreWrEn;
    assign rd_own_host_d = host_gnt && !bus.HostWrEn;

    // Read returns are masked during reset so an in-flight response is dropped.
    assign bus.CoreRdValidQ104H = rd_own_core_q && Rst;
    assign bus.HostRdValid      = rd_own_host_q && Rst;
    assign bus.HostRdData       = bus.HostRdValid ? bus.MemRdData : '0;
    assign bus.HostReqReady     = host_rdy;
    assign bus.CoreStall        = stall;
    assign bus.CoreHoldAck      = hold_ack;

endmodule
